// File: rtl/obstacle_collision_if.sv
// Bundle between the game state controller and the obstacle engine.
// No valid/ready here: inputs are levels plus a scroll square wave, outputs are registered levels.
interface obstacle_collision_if #(
    parameter int NUM_OBS = 4
);
    logic                   obstacle_enable;
    logic                   tick;
    logic [6:0]             player_y;
    logic                   collision_detected;
    logic [NUM_OBS-1:0]     obs_valid;
    logic [NUM_OBS*7-1:0]   obs_x;
    logic [NUM_OBS*7-1:0]   obs_gap_y;
    logic [7:0]             obs_passed;

    modport master (
        output obstacle_enable, tick, player_y,
        input  collision_detected, obs_valid, obs_x, obs_gap_y, obs_passed
    );

    modport slave (
        input  obstacle_enable, tick, player_y,
        output collision_detected, obs_valid, obs_x, obs_gap_y, obs_passed
    );
endinterface

// File: rtl/obstacle_collision_engine.sv
// Spawns LFSR-placed gap obstacles at the right edge, scrolls them left per tick edge,
// retires them at column 0 and flags a sticky collision with the fixed-column player.
module obstacle_collision_engine #(
    parameter int          NUM_OBS   = 4,
    parameter int          X_MAX     = 127,
    parameter int          PLAYER_X  = 8,
    parameter int          PLAYER_H  = 8,
    parameter int          GAP_H     = 24,
    parameter int          Y_MAX     = 64,
    parameter int          SPAWN_GAP = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_collision_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int XW = 7;
    localparam int SW = $clog2(SPAWN_GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               tick_q;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [SW-1:0]      spacing_q, spacing_d;
    logic [NUM_OBS-1:0] valid_q, valid_d;
    logic [XW-1:0]      x_q [NUM_OBS];
    logic [XW-1:0]      x_d [NUM_OBS];
    logic [XW-1:0]      gap_q [NUM_OBS];
    logic [XW-1:0]      gap_d [NUM_OBS];
    logic [7:0]         passed_q, passed_d;
    logic               coll_q, coll_d;

    logic               step;
    logic               hit;
    logic               any_free;
    logic [NUM_OBS-1:0] spawn_sel;
    logic [SW-1:0]      spacing_step;
    logic               spawn;
    logic [XW-1:0]      gap_new;
    logic [XW-1:0]      g_ext;

    assign step  = bus.tick & ~tick_q;
    assign g_ext = {1'b0, lfsr_q[5:0]};
    assign gap_new = (g_ext <= XW'(Y_MAX - GAP_H)) ? g_ext : g_ext - XW'(GAP_H);

    // Collision uses registered slots; the height sum is done at 8 bits so tall player_y cannot wrap.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (valid_q[i] && x_q[i] == XW'(PLAYER_X) &&
                !(gap_q[i] <= bus.player_y &&
                  ({1'b0, bus.player_y} + 8'(PLAYER_H)) <= ({1'b0, gap_q[i]} + 8'(GAP_H))))
                hit = 1'b1;
        end
    end

    // Lowest free slot as seen before this step, so a slot expiring now is not reused yet.
    always_comb begin
        any_free  = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!valid_q[i] && !any_free) begin
                spawn_sel[i] = 1'b1;
                any_free     = 1'b1;
            end
        end
    end

    // The spacing count includes the current step, so spawns land exactly SPAWN_GAP steps apart.
    assign spacing_step = (spacing_q >= SW'(SPAWN_GAP)) ? spacing_q : spacing_q + SW'(1);
    assign spawn        = any_free && (spacing_step >= SW'(SPAWN_GAP));

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        spacing_d = spacing_q;
        valid_d   = valid_q;
        x_d       = x_q;
        gap_d     = gap_q;
        passed_d  = passed_q;
        coll_d    = coll_q;

        if (!bus.obstacle_enable) begin
            state_d   = S_IDLE;
            valid_d   = '0;
            passed_d  = '0;
            coll_d    = 1'b0;
            spacing_d = SW'(SPAWN_GAP);
            for (int i = 0; i < NUM_OBS; i++) begin
                x_d[i]   = '0;
                gap_d[i] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    coll_d  = 1'b0;
                end
                S_RUN: begin
                    if (hit) begin
                        state_d = S_HIT;
                        coll_d  = 1'b1;
                    end else if (step) begin
                        for (int i = 0; i < NUM_OBS; i++) begin
                            if (valid_q[i] && x_q[i] == '0) begin
                                valid_d[i] = 1'b0;
                                if (passed_d != 8'hFF) passed_d = passed_d + 8'd1;
                            end else if (valid_q[i]) begin
                                x_d[i] = x_q[i] - XW'(1);
                            end
                            if (spawn && spawn_sel[i]) begin
                                valid_d[i] = 1'b1;
                                x_d[i]     = XW'(X_MAX);
                                gap_d[i]   = gap_new;
                            end
                        end
                        spacing_d = spawn ? '0 : spacing_step;
                    end
                end
                S_HIT: begin
                    coll_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tick_q    <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            spacing_q <= SW'(SPAWN_GAP);
            valid_q   <= '0;
            passed_q  <= '0;
            coll_q    <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i]   <= '0;
                gap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tick_q    <= bus.tick;
            lfsr_q    <= lfsr_d;
            spacing_q <= spacing_d;
            valid_q   <= valid_d;
            passed_q  <= passed_d;
            coll_q    <= coll_d;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i]   <= x_d[i];
                gap_q[i] <= gap_d[i];
            end
        end
    end

    logic [NUM_OBS*XW-1:0] x_flat, gap_flat;
    always_comb begin
        x_flat   = '0;
        gap_flat = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            x_flat[i*XW +: XW]   = x_q[i];
            gap_flat[i*XW +: XW] = gap_q[i];
        end
    end

    assign bus.obs_x              = x_flat;
    assign bus.obs_gap_y          = gap_flat;
    assign bus.obs_valid          = valid_q;
    assign bus.obs_passed         = passed_q;
    assign bus.collision_detected = coll_q;
    assign dbg_state              = state_q;
endmodule

// File: doc/obstacle_collision_engine.md
Name: obstacle_collision_engine

Overview:
- Obstacle stage directly downstream of the game state controller.
- Consumes `obstacle_enable`, the scroll square wave `tick` and `player_y`.
- Spawns pseudo-random gap obstacles at the right edge, scrolls them left one column per tick, and retires them at column 0.
- Produces the `collision_detected` level the controller uses for its ACTIVE->END transition, plus obstacle positions for the display/Arduino link.

Parameters:
- NUM_OBS, 4, number of obstacle slots.
- X_MAX, 127, spawn column; columns 0..X_MAX, 7-bit.
- PLAYER_X, 8, fixed player column.
- PLAYER_H, 8, player height in rows.
- GAP_H, 24, vertical opening height of each obstacle.
- Y_MAX, 64, top row limit; matches the player_y range 0..64.
- SPAWN_GAP, 32, minimum scroll steps between spawns.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- obstacle_enable  in  1  high while the game is ACTIVE.
- tick  in  1  scroll square wave; each rising edge is one scroll step.
- player_y  in  7  player bottom row, 0..64.
- collision_detected  out  1  sticky collision flag.
- obs_valid  out  NUM_OBS  slot occupied flags.
- obs_x  out  NUM_OBS*7  slot columns, slot 0 in the LSBs.
- obs_gap_y  out  NUM_OBS*7  slot gap bottom rows.
- obs_passed  out  8  count of obstacles retired this game; saturates at 255.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0 and all slots invalid.
  - LFSR = LFSR_SEED, spacing counter = SPAWN_GAP (first spawn allowed on the first step), FSM = IDLE.
  - tick edge register = 0.
- Step detection:
  - step = tick & ~tick_d, where tick_d is registered every clk.
  - One step per tick rising edge.
- LFSR:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every clk regardless of state.
- FSM:
  - IDLE: slots cleared, obs_passed cleared, collision 0. Moves to RUN when obstacle_enable = 1.
  - RUN: scroll, spawn and check. Moves to HIT on a collision condition. Moves to IDLE if obstacle_enable = 0.
  - HIT: collision_detected held at 1; slots frozen with no scroll or spawn. Moves to IDLE when obstacle_enable = 0.
- Enable dropped in any state: next cycle is IDLE, and all slots plus obs_passed are cleared.
- Scroll (RUN, on step):
  - Each valid slot with x > 0 has x decremented by 1.
  - A valid slot with x == 0 becomes invalid, and obs_passed increments (saturating at 255).
- Spawn (RUN, on step):
  - Condition: spacing counter >= SPAWN_GAP and at least one slot was free before this step.
  - Target: the lowest-index free slot. It becomes valid with x = X_MAX.
  - gap_y is taken from the low 6 LFSR bits g: gap_y = g if g <= Y_MAX-GAP_H, else g-GAP_H. Range 0..40.
  - Spacing counter resets to 0 on spawn; otherwise it increments per step, saturating at SPAWN_GAP.
- Simultaneous step events:
  - A slot freed by expiry in a step is not reusable until the next step.
  - A newly spawned slot is not decremented in its spawn step.
- Collision check:
  - Evaluated every clk in RUN on the registered slot state.
  - A slot hits if valid, x == PLAYER_X, and NOT (gap_y <= player_y AND player_y+PLAYER_H <= gap_y+GAP_H).
  - The addition is done at 8-bit width.
  - On any hit, the FSM enters HIT and collision_detected = 1 on the next clk edge. Latency is 1 cycle from slot/player state to flag.
- player_y > Y_MAX is treated as-is; no clamping.
- Outputs are registered except the obs_* buses, which are the slot registers directly.

Test Plan:
- Reset, then obstacle_enable=1, toggle tick: first rising edge gives slot 0 valid, x=127, gap_y derived from LFSR (model check).
- After 32 steps the second spawn lands in slot 1, and slot 0 x = 95.
- An obstacle reaching x=0 retires on the next step and obs_passed increments to 1. Expiry plus spawn in the same step with all slots full: no spawn until the following step.
- Hold player_y inside the gap (player_y = gap_y) as the obstacle crosses x=8: collision stays 0.
- Set player_y = gap_y+GAP_H-PLAYER_H+1: collision_detected = 1 one clk after x=8, stays high, and slots freeze.
- Drop obstacle_enable in HIT: next clk collision=0, obs_valid=0, obs_passed=0. Assert rst_n low mid-scroll: all outputs 0 immediately (async).
